demux_rr_sched: RTL and testbench

- Sequencing controller for a 4-way, width-bit demultiplexer datapath.
- Accepts one word at a time from a valid/ready source and holds it in a single-entry register.
- Each word goes to output channel o0..o3. The channel is chosen by round-robin or by an explicit destination.
- The block drives the channel select and the per-channel valid signals, waits for the chosen consumer's ready, and optionally reroutes or drops the word on timeout.

---
 rtl/demux_rr_sched.sv | 96 +++++++++
 tb/tb_demux_rr_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: 4-way demux sequencer (round-robin or directed) with optional HOLD timeout.
// Define DEMUX_RR_SCHED_CNT_EN to add per-channel transfer counters (cnt, cnt_clr).
module demux_rr_sched #(
  parameter int width = 8,
  parameter int snum = 2,
  parameter int timeout = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             mode,
  input  logic [snum-1:0]  dest,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [snum-1:0]  sel,
  output logic             busy,
  output logic             drop
`ifdef DEMUX_RR_SCHED_CNT_EN
  ,
  output logic [31:0]      cnt,
  input  logic             cnt_clr
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [snum-1:0] rr_ptr, tgt, nxt;
  logic [7:0] wait_cnt;
  logic held_mode, xfer, expire;
  logic [width-1:0] o_q [4];
  assign i_ready = state == IDLE;
  assign tgt = mode ? dest : rr_ptr;
  assign nxt = sel + snum'(1);
  assign xfer = state == HOLD && o_valid[sel] && o_ready[sel];
  // wait_cnt reaches timeout-1 on the last waiting cycle, so the action lands timeout cycles after the word appears
  assign expire = timeout != 0 && wait_cnt == 8'(timeout - 1);
  assign o0 = o_q[0];
  assign o1 = o_q[1];
  assign o2 = o_q[2];
  assign o3 = o_q[3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      wait_cnt <= '0;
      held_mode <= 1'b0;
      o_valid <= '0;
      sel <= '0;
      busy <= 1'b0;
      drop <= 1'b0;
      for (int n = 0; n < 4; n++) o_q[n] <= '0;
    end else begin
      drop <= 1'b0;
      if (state == IDLE) begin
        if (i_valid) begin
          state <= HOLD;
          held_mode <= mode;
          sel <= tgt;
          busy <= 1'b1;
          wait_cnt <= '0;
          o_valid <= 4'(1) << tgt;
          for (int n = 0; n < 4; n++) o_q[n] <= tgt == snum'(n) ? i : '0;
        end
      end else if (xfer) begin
        state <= IDLE;
        busy <= 1'b0;
        o_valid <= '0;
        for (int n = 0; n < 4; n++) o_q[n] <= '0;
        if (!held_mode) rr_ptr <= nxt;
      end else if (expire && !held_mode) begin
        sel <= nxt;
        wait_cnt <= '0;
        o_valid <= 4'(1) << nxt;
        for (int n = 0; n < 4; n++) o_q[n] <= nxt == snum'(n) ? o_q[sel] : '0;
      end else if (expire) begin
        state <= IDLE;
        busy <= 1'b0;
        drop <= 1'b1;
        o_valid <= '0;
        for (int n = 0; n < 4; n++) o_q[n] <= '0;
      end else if (wait_cnt != 8'hff) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
`ifdef DEMUX_RR_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (xfer) cnt[8*sel +: 8] <= cnt[8*sel +: 8] + 8'd1;
`endif
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: directed checks of demux_rr_sched; dut_a has no timeout, dut_b uses timeout = 3.
module tb_demux_rr_sched;
  logic clk, rst_n, i_valid, mode;
  logic [7:0] i;
  logic [1:0] dest;
  logic [3:0] o_ready;
  logic [7:0] a [4];
  logic [7:0] b [4];
  logic [3:0] a_valid, b_valid;
  logic [1:0] a_sel, b_sel;
  logic a_irdy, b_irdy, a_busy, b_busy, a_drop, b_drop;
  int pass = 0, total = 0;
`ifdef DEMUX_RR_SCHED_CNT_EN
  logic [31:0] a_cnt, b_cnt;
  logic cnt_clr;
`endif

  demux_rr_sched #(.width(8), .snum(2), .timeout(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(a_irdy),
    .mode(mode), .dest(dest), .o0(a[0]), .o1(a[1]), .o2(a[2]), .o3(a[3]),
    .o_valid(a_valid), .o_ready(o_ready), .sel(a_sel), .busy(a_busy), .drop(a_drop)
`ifdef DEMUX_RR_SCHED_CNT_EN
    , .cnt(a_cnt), .cnt_clr(cnt_clr)
`endif
  );

  demux_rr_sched #(.width(8), .snum(2), .timeout(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(b_irdy),
    .mode(mode), .dest(dest), .o0(b[0]), .o1(b[1]), .o2(b[2]), .o3(b[3]),
    .o_valid(b_valid), .o_ready(o_ready), .sel(b_sel), .busy(b_busy), .drop(b_drop)
`ifdef DEMUX_RR_SCHED_CNT_EN
    , .cnt(b_cnt), .cnt_clr(cnt_clr)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input logic m, input logic [1:0] d);
    i = w;
    mode = m;
    dest = d;
    i_valid = 1;
    step();
    i_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    @(negedge clk) rst_n = 1;
    step();
  endtask

  initial begin
    rst_n = 0; i = 0; i_valid = 0; mode = 0; dest = 0; o_ready = 0;
`ifdef DEMUX_RR_SCHED_CNT_EN
    cnt_clr = 0;
`endif
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_irdy", a_irdy, 1);
    chk("rst_sel", a_sel, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_o0", a[0], 0);
    @(negedge clk) rst_n = 1;
    step();
    // round-robin sweep, wraps after o3
    o_ready = 4'hf;
    for (int k = 0; k < 5; k++) begin
      send(8'hA0 + 8'(k * 16), 0, 0);
      chk("rr_valid", a_valid, 4'(1) << (k % 4));
      chk("rr_data", a[k % 4], 8'hA0 + 8'(k * 16));
      chk("rr_sel", a_sel, k % 4);
      chk("rr_irdy", a_irdy, 0);
      step();
      chk("rr_done", {a_busy, a_valid}, 0);
    end
`ifdef DEMUX_RR_SCHED_CNT_EN
    chk("cnt_rr", a_cnt, 32'h01010102);
`endif
    // directed word leaves rr_ptr (now 1) alone
    o_ready = 4'b0100;
    send(8'h5A, 1, 2);
    chk("dir_valid", a_valid, 4'b0100);
    chk("dir_data", a[2], 8'h5A);
    chk("dir_sel", a_sel, 2);
    step();
    chk("dir_done", a_valid, 0);
    o_ready = 4'hf;
    send(8'h11, 0, 3);
    chk("dir_rr_valid", a_valid, 4'b0010);
    chk("dir_rr_data", a[1], 8'h11);
    step();
    send(8'h01, 0, 0);
    step();
    send(8'h02, 0, 0);
    step();
    // backpressure on o0, other readies ignored
    o_ready = 4'b1110;
    send(8'h33, 0, 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", a_valid, 4'b0001);
      chk("bp_data", a[0], 8'h33);
      chk("bp_irdy", a_irdy, 0);
      step();
    end
    o_ready = 4'hf;
    step();
    chk("bp_done", {a_busy, a_valid}, 0);
    chk("bp_irdy_after", a_irdy, 1);
    // reset while holding on o1
    o_ready = 4'h0;
    send(8'hAA, 0, 0);
    chk("mid_hold", a[1], 8'hAA);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_o1", a[1], 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_sel", a_sel, 0);
    chk("mid_rst_irdy", a_irdy, 1);
    chk("mid_rst_drop", a_drop, 0);
`ifdef DEMUX_RR_SCHED_CNT_EN
    chk("mid_rst_cnt", a_cnt, 0);
`endif
    @(negedge clk) rst_n = 1;
    step();
    o_ready = 4'hf;
    send(8'h44, 0, 0);
    chk("post_rst_valid", a_valid, 4'b0001);
    chk("post_rst_data", a[0], 8'h44);
    step();
    do_reset();
    // timeout reroute on dut_b
    o_ready = 4'b0010;
    send(8'h77, 0, 0);
    chk("to_valid0", b_valid, 4'b0001);
    chk("to_data0", b[0], 8'h77);
    step();
    step();
    chk("to_sel_wait", b_sel, 0);
    chk("to_valid_wait", b_valid, 4'b0001);
    step();
    chk("to_sel", b_sel, 1);
    chk("to_data1", b[1], 8'h77);
    chk("to_o0_clr", b[0], 0);
    chk("to_valid1", b_valid, 4'b0010);
    step();
    chk("to_done", {b_busy, b_valid}, 0);
    o_ready = 4'hf;
    send(8'h66, 0, 0);
    chk("to_rr2", b_valid, 4'b0100);
    step();
    // timeout drop on dut_b, rr_ptr stays at 3
    o_ready = 4'h0;
    send(8'h99, 1, 3);
    chk("drop_valid", b_valid, 4'b1000);
    chk("drop_early0", b_drop, 0);
    step();
    step();
    chk("drop_early2", b_drop, 0);
    step();
    chk("drop_pulse", b_drop, 1);
    chk("drop_busy", b_busy, 0);
    chk("drop_valid_clr", b_valid, 0);
    chk("drop_o3_clr", b[3], 0);
    step();
    chk("drop_once", b_drop, 0);
    o_ready = 4'hf;
    send(8'h55, 0, 0);
    chk("drop_rr", b_valid, 4'b1000);
    step();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
